// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state encoding and latency classes for the ALU op sequencer.
package alu_seq_pkg;

    localparam logic [4:0] OpLoad = 5'b00000;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpShr  = 5'b00111;
    localparam logic [4:0] OpShra = 5'b01000;
    localparam logic [4:0] OpShl  = 5'b01001;
    localparam logic [4:0] OpRor  = 5'b01010;
    localparam logic [4:0] OpRol  = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpMul  = 5'b01110;
    localparam logic [4:0] OpDiv  = 5'b01111;
    localparam logic [4:0] OpNeg  = 5'b10000;
    localparam logic [4:0] OpNot  = 5'b10001;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StCapture,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        LatSingle,
        LatMul,
        LatDiv,
        LatIllegal
    } lat_class_e;

    // Legal opcodes are Load plus the contiguous Add..Not block.
    function automatic lat_class_e op_class(input logic [4:0] op);
        lat_class_e cls;
        if (op == OpMul) begin
            cls = LatMul;
        end else if (op == OpDiv) begin
            cls = LatDiv;
        end else if (op == OpLoad || (op >= OpAdd && op <= OpNot)) begin
            cls = LatSingle;
        end else begin
            cls = LatIllegal;
        end
        return cls;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-facing and status signals of the ALU op sequencer.
interface alu_op_sequencer_if;

    logic        start;
    logic [4:0]  op;
    logic        inc_pc;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_ctl;
    logic        alu_incpc;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic        busy;
    logic        done;
    logic        err;

    // Requester/ALU environment side.
    modport master (
        output start, op, inc_pc, a_in, b_in, z_hi, z_lo,
        input  alu_a, alu_b, alu_ctl, alu_incpc, result_hi, result_lo, busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  start, op, inc_pc, a_in, b_in, z_hi, z_lo,
        output alu_a, alu_b, alu_ctl, alu_incpc, result_hi, result_lo, busy, done, err
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode legality check and EXEC dwell selection.
module alu_op_decode
    import alu_seq_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic [4:0] op,
    input  logic       inc_pc,
    output logic       legal,
    output logic [3:0] dwell
);

    always_comb begin
        legal = 1'b1;
        dwell = 4'd1;
        // A PC increment ignores the opcode entirely.
        if (!inc_pc) begin
            case (op_class(op))
                LatMul:     dwell = 4'(MUL_CYCLES);
                LatDiv:     dwell = 4'(DIV_CYCLES);
                LatIllegal: legal = 1'b0;
                default:    dwell = 4'd1;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation: latch, dwell in EXEC, capture result, pulse done.
// Optional DIV_ZERO_CHECK_EN rejects Divide by zero with err and zeroed results.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input logic               clock,
    input logic               clear,
    alu_op_sequencer_if.slave bus
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  op_q, op_d;
    logic        incpc_q, incpc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        fault_q, fault_d;
    logic        zero_res_q, zero_res_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;

    logic        legal;
    logic [3:0]  dwell;
    logic        div_zero;

    alu_op_decode #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_decode (
        .op     (bus.op),
        .inc_pc (bus.inc_pc),
        .legal  (legal),
        .dwell  (dwell)
    );

`ifdef DIV_ZERO_CHECK_EN
    assign div_zero = !bus.inc_pc && (bus.op == OpDiv) && (bus.b_in == 32'd0);
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            op_q       <= 5'd0;
            incpc_q    <= 1'b0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            fault_q    <= 1'b0;
            zero_res_q <= 1'b0;
            res_hi_q   <= 32'd0;
            res_lo_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            incpc_q    <= incpc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            fault_q    <= fault_d;
            zero_res_q <= zero_res_d;
            res_hi_q   <= res_hi_d;
            res_lo_q   <= res_lo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        incpc_d    = incpc_q;
        a_d        = a_q;
        b_d        = b_q;
        fault_d    = fault_q;
        zero_res_d = zero_res_q;
        res_hi_d   = res_hi_q;
        res_lo_d   = res_lo_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d       = bus.op;
                    incpc_d    = bus.inc_pc;
                    a_d        = bus.a_in;
                    b_d        = bus.b_in;
                    fault_d    = !legal || div_zero;
                    zero_res_d = div_zero;
                    cnt_d      = (!legal || div_zero) ? 4'd1 : dwell;
                    state_d    = StExec;
                end
            end
            StExec: begin
                // A rejected request spends its single cycle here with the ALU idle.
                if (fault_q) begin
                    cnt_d   = 4'd0;
                    state_d = StDone;
                    if (zero_res_q) begin
                        res_hi_d = 32'd0;
                        res_lo_d = 32'd0;
                    end
                end else if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapture: begin
                res_hi_d = bus.z_hi;
                res_lo_d = bus.z_lo;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.alu_a     = a_q;
        bus.alu_b     = b_q;
        bus.alu_ctl   = 5'd0;
        bus.alu_incpc = 1'b0;
        if (state_q == StExec && !fault_q) begin
            bus.alu_ctl   = op_q;
            bus.alu_incpc = incpc_q;
        end
        bus.result_hi = res_hi_q;
        bus.result_lo = res_lo_q;
        bus.busy      = (state_q != StIdle);
        bus.done      = (state_q == StDone);
        bus.err       = (state_q == StDone) && fault_q;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus randomized transactions.
module tb_alu_op_sequencer;

    localparam int MulCycles = 4;
    localparam int DivCycles = 8;

    logic clock;
    logic clear;
    int   vectors;
    int   miscompares;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(
        .MUL_CYCLES (MulCycles),
        .DIV_CYCLES (DivCycles)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU function: {hi, lo} result for an opcode.
    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic inc,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (inc) begin
            r = {32'd0, a + 32'd1};
        end else begin
            case (op)
                5'd0:  r = {32'd0, b};
                5'd3:  r = {32'd0, a + b};
                5'd4:  r = {32'd0, a - b};
                5'd5:  r = {32'd0, a & b};
                5'd6:  r = {32'd0, a | b};
                5'd7:  r = {32'd0, a >> b[4:0]};
                5'd9:  r = {32'd0, a << b[4:0]};
                5'd14: r = {32'd0, a} * {32'd0, b};
                5'd15: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
                5'd16: r = {32'd0, -a};
                5'd17: r = {32'd0, ~a};
                default: r = {32'd0, a ^ b};
            endcase
        end
        return r;
    endfunction

    // ALU result register: recomputed every cycle from whatever the sequencer drives.
    always @(posedge clock) begin
        if (clear) begin
            bus.z_hi <= 32'd0;
            bus.z_lo <= 32'd0;
        end else begin
            {bus.z_hi, bus.z_lo} <= alu_fn(bus.alu_ctl, bus.alu_incpc, bus.alu_a, bus.alu_b);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction; poke_k > 0 raises a stray start during that observation cycle.
    task automatic txn(input logic [4:0] op, input logic inc, input logic [31:0] a,
                       input logic [31:0] b, input int poke_k);
        bit legal;
        bit div0;
        bit fault;
        int dwell;
        int lat;
        bit in_exec;
        logic [63:0] r;
        legal = inc || (op == 5'd0) || (op >= 5'd3 && op <= 5'd17);
`ifdef DIV_ZERO_CHECK_EN
        div0 = !inc && (op == 5'd15) && (b == 32'd0);
`else
        div0 = 1'b0;
`endif
        fault = !legal || div0;
        dwell = inc ? 1 : (op == 5'd14) ? MulCycles : (op == 5'd15) ? DivCycles : 1;
        lat   = fault ? 2 : dwell + 2;
        if (div0) begin
            exp_hi = 32'd0;
            exp_lo = 32'd0;
        end else if (!fault) begin
            r = alu_fn(op, inc, a, b);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
        end

        @(negedge clock);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.inc_pc = inc;
        bus.a_in   = a;
        bus.b_in   = b;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
        check("alu_a", 64'(bus.alu_a), 64'(a));
        check("alu_b", 64'(bus.alu_b), 64'(b));
        for (int k = 1; k <= lat + 1; k++) begin
            if (k > 1) begin
                @(posedge clock);
                @(negedge clock);
            end
            bus.start = (k == poke_k);
            if (k == poke_k) bus.op = 5'd3;
            in_exec = !fault && (k <= dwell);
            check("busy", 64'(bus.busy), 64'(k <= lat));
            check("alu_ctl", 64'(bus.alu_ctl), in_exec ? 64'(op) : 64'd0);
            check("alu_incpc", 64'(bus.alu_incpc), 64'(in_exec && inc));
            check("done", 64'(bus.done), 64'(k == lat));
            check("err", 64'(bus.err), 64'((k == lat) && fault));
            if (k >= lat) begin
                check("result_hi", 64'(bus.result_hi), 64'(exp_hi));
                check("result_lo", 64'(bus.result_lo), 64'(exp_lo));
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
        check({tag, "_alu_a"}, 64'(bus.alu_a), 64'd0);
        check({tag, "_alu_b"}, 64'(bus.alu_b), 64'd0);
        check({tag, "_alu_ctl"}, 64'(bus.alu_ctl), 64'd0);
        check({tag, "_alu_incpc"}, 64'(bus.alu_incpc), 64'd0);
        check({tag, "_res"}, {bus.result_hi, bus.result_lo}, 64'd0);
    endtask

    initial begin
        logic [4:0]  rop;
        logic        rinc;
        logic [31:0] ra;
        logic [31:0] rb;
        vectors     = 0;
        miscompares = 0;
        exp_hi      = 32'd0;
        exp_lo      = 32'd0;
        clear       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 5'd0;
        bus.inc_pc  = 1'b0;
        bus.a_in    = 32'd0;
        bus.b_in    = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        check_all_zero("reset");

        txn(5'b00011, 1'b0, 32'd3, 32'd5, 0);
        check("add_lo", 64'(bus.result_lo), 64'd8);
        check("add_hi", 64'(bus.result_hi), 64'd0);

        txn(5'b01110, 1'b0, 32'h0001_0000, 32'h0001_0000, 0);
        check("mul_hi", 64'(bus.result_hi), 64'd1);
        check("mul_lo", 64'(bus.result_lo), 64'd0);

        // Stray start mid-divide must be ignored.
        txn(5'b01111, 1'b0, 32'd17, 32'd5, 4);
        check("div_lo", 64'(bus.result_lo), 64'd3);
        check("div_hi", 64'(bus.result_hi), 64'd2);

        txn(5'b01111, 1'b0, 32'd9, 32'd0, 0);
        txn(5'b00011, 1'b0, 32'd100, 32'd23, 0);
        txn(5'b00010, 1'b0, 32'd7, 32'd7, 0);
        check("illegal_keeps_lo", 64'(bus.result_lo), 64'd123);
        txn(5'b00010, 1'b1, 32'h0000_0040, 32'd0, 0);
        txn(5'b11111, 1'b0, 32'd1, 32'd2, 0);

        // Clear in the middle of a multiply.
        @(negedge clock);
        bus.start  = 1'b1;
        bus.op     = 5'b01110;
        bus.inc_pc = 1'b0;
        bus.a_in   = 32'd6;
        bus.b_in   = 32'd7;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("clr_busy_before", 64'(bus.busy), 64'd1);
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        check_all_zero("clear");
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(posedge clock);
        @(negedge clock);
        check("clear_no_done", 64'(bus.done), 64'd0);
        txn(5'b00011, 1'b0, 32'd40, 32'd2, 0);
        check("post_clear_add", 64'(bus.result_lo), 64'd42);

        for (int i = 0; i < 60; i++) begin
            rop  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(18, 31))
                                                : 5'($urandom_range(0, 17));
            rinc = ($urandom_range(0, 4) == 0);
            ra   = $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (rop == 5'd15 && rb != 32'd0) rb = rb >> $urandom_range(0, 31);
            txn(rop, rinc, ra, rb, ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
